// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART receiver and register file; the head entry is shown ahead of the pop.
// Optional idle-timeout counter is built only when UART_RX_FIFO_TIMEOUT_EN is defined.
module uart_rx_fifo #(
  parameter int DEPTH         = 16,
  parameter int LVL_W         = $clog2(DEPTH + 1),
  parameter int TIMEOUT_TICKS = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_valid,
  input  logic [7:0]       wr_data,
  input  logic             wr_error,
  input  logic             rd_req,
  output logic [7:0]       rd_data,
  output logic             rd_error,
  output logic             empty,
  output logic             full,
  output logic [LVL_W-1:0] level,
  input  logic [LVL_W-1:0] threshold,
  output logic             thr_reached,
  output logic             overflow,
  input  logic             overflow_clr,
  input  logic             sck_rising_edge,
  output logic             timeout
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [8:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic             overflow_reg;
  logic             push;
  logic             pop;
  logic             drop;

  assign empty = (level_reg == '0);
  assign full  = (level_reg == LVL_W'(DEPTH));
  assign level = level_reg;

  // When full, a concurrent pop frees the slot the push lands in, so the write is accepted.
  assign pop  = rd_req && !empty && !flush;
  assign push = wr_valid && (!full || rd_req) && !flush;
  assign drop = wr_valid && full && !rd_req && !flush;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {wr_error, wr_data};
  end

  // Gated so the head reads as zero out of reset, before any storage has been written.
  assign {rd_error, rd_data} = empty ? 9'd0 : mem[rd_ptr_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (push && !pop)      level_reg <= level_reg + LVL_W'(1);
      else if (pop && !push) level_reg <= level_reg - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            overflow_reg <= 1'b0;
    else if (drop)         overflow_reg <= 1'b1;
    else if (overflow_clr) overflow_reg <= 1'b0;
  end

  assign overflow    = overflow_reg;
  assign thr_reached = (threshold != '0) && (level_reg >= threshold);

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);

  logic [TO_W-1:0] idle_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      idle_reg <= '0;
    else if (push || pop || flush || empty)
      idle_reg <= '0;
    else if (sck_rising_edge && (idle_reg != TO_W'(TIMEOUT_TICKS)))
      idle_reg <= idle_reg + TO_W'(1);
  end

  assign timeout = (idle_reg == TO_W'(TIMEOUT_TICKS)) && !empty;
`else
  logic unused_sck;
  assign unused_sck = sck_rising_edge;
  assign timeout    = 1'b0;
`endif

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer between the UART receiver and the UART register file. Captures each byte and its framing-error flag when the receiver reports valid data. Holds up to DEPTH entries, presents the oldest entry to the register file, and pops it when RDR is read. Provides fill level, threshold, overflow and an optional idle-timeout indication for interrupt generation.

Parameters:
DEPTH, 16, number of entries; power of two, minimum 2
LVL_W, $clog2(DEPTH+1), width of the level and threshold fields (derived, not overridden)
TIMEOUT_TICKS, 40, sck_rising_edge ticks of inactivity before timeout asserts (4 frames of 10 bits); minimum 1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of contents, pointers, level and timeout
wr_valid  in  1  one-cycle strobe: receiver has a byte
wr_data  in  8  received byte
wr_error  in  1  framing error associated with wr_data
rd_req  in  1  pop strobe (RDR read)
rd_data  out  8  head entry byte
rd_error  out  1  head entry error flag
empty  out  1  no entries stored
full  out  1  DEPTH entries stored
level  out  LVL_W  current entry count, 0..DEPTH
threshold  in  LVL_W  programmed fill threshold
thr_reached  out  1  level >= threshold and threshold != 0
overflow  out  1  sticky: a write was dropped
overflow_clr  in  1  clears overflow
sck_rising_edge  in  1  bit-rate tick from the serial clock generator
timeout  out  1  idle timeout (see Optional Feature)

Behaviour:
- Reset (rst_n low, any time): pointers = 0, level = 0, empty = 1, full = 0, overflow = 0, timeout = 0, rd_data = 0, rd_error = 0, thr_reached = 0. Storage array is not reset.
- Storage: DEPTH x 9 bits {error, data}. Read and write pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Show-ahead read: rd_data and rd_error always reflect the entry at the read pointer (combinational from storage). Values are meaningless while empty = 1 and are 0 after reset.
- Push: wr_valid && !full. Entry is written at the write pointer, which increments. The new data is visible on rd_data the next cycle if the FIFO was empty.
- Pop: rd_req && !empty. Read pointer increments and rd_data updates the next cycle. A pop while empty is ignored, with no underflow flag.
- Simultaneous push and pop:
  - Not empty: both occur and level is unchanged. This includes the full case: when full, the push succeeds because the pop frees a slot, and no overflow is raised.
  - Empty: only the push occurs.
- Push while full without a pop: the byte is dropped, storage is untouched, and overflow is set next cycle.
- overflow_clr clears overflow. If a drop happens in the same cycle, set wins.
- Priority:
  - flush overrides push and pop in the same cycle; the FIFO is empty the next cycle. flush does not clear overflow.
  - reset overrides everything.
- level, empty, full and thr_reached are all registered or derived from registered state, and update one cycle after the push or pop.
- With threshold > DEPTH, thr_reached never asserts.
- Latency: wr_valid to !empty is 1 cycle. rd_req to next head is 1 cycle.

Optional Feature:
UART_RX_FIFO_TIMEOUT_EN
- Defined:
  - An idle counter (width covers TIMEOUT_TICKS) resets to 0 on any successful push, any successful pop, on flush, or while empty.
  - Otherwise it increments on each sck_rising_edge and saturates at TIMEOUT_TICKS.
  - timeout = 1 when the counter equals TIMEOUT_TICKS and the FIFO is not empty. It deasserts the cycle after the next push, pop or flush.
- Undefined: the counter is not instantiated, timeout is tied to 0, and sck_rising_edge is unused.

Test Plan:
- Reset, then push 0xA5 (wr_error=0), then 0x3C (wr_error=1) → level=2, rd_data=0xA5 / rd_error=0; after pop, rd_data=0x3C / rd_error=1, level=1.
- Push 16 bytes 0x00..0x0F with DEPTH=16 → full=1, level=16. Push 0xFF → dropped and overflow=1. Pop all 16 → sequence 0x00..0x0F, empty=1, overflow still 1. Pulse overflow_clr → overflow=0.
- At full, push 0x55 and pop in the same cycle → level stays 16, no overflow, 0x55 appears as the last entry. Pointers wrap correctly over 3 full fill/drain cycles.
- threshold=4: push 3 → thr_reached=0; push 4th → thr_reached=1 next cycle; pop 1 → thr_reached=0. threshold=0 → never asserts.
- Push 5 entries, then flush asserted together with wr_valid and rd_req → next cycle empty=1, level=0; the concurrent push is discarded.
- With UART_RX_FIFO_TIMEOUT_EN: push 1 byte, apply 39 ticks → timeout=0; 40th tick → timeout=1; pop → timeout=0 next cycle. With the FIFO empty, 100 ticks → timeout stays 0.
